// File: rtl/mux_serializer_ctrl_if.sv
// Handshake and mux-side bundle for the mux-based serializer controller.
// The master modport is the controller; slave is the word source / mux / consumer side.
interface mux_serializer_ctrl_if #(
   parameter int N = 8,
   parameter int R = 3
);
   logic         in_valid;
   logic [N-1:0] in_data;
   logic         in_ready;
   logic [N-1:0] mux_a;
   logic [R-1:0] mux_s;
   logic         mux_y;
   logic         ser_valid;
   logic         ser_bit;
   logic         ser_last;
   logic         ser_ready;
   logic         busy;

   modport master (
      input  in_valid, in_data, mux_y, ser_ready,
      output in_ready, mux_a, mux_s, ser_valid, ser_bit, ser_last, busy
   );

   modport slave (
      output in_valid, in_data, mux_y, ser_ready,
      input  in_ready, mux_a, mux_s, ser_valid, ser_bit, ser_last, busy
   );
endinterface

// File: rtl/mux_serializer_ctrl.sv
// Serializes an N-bit word LSB-first by stepping the select of an external N:1 mux.
// The held word and the select are registered; the serial bit is the mux result itself.
module mux_serializer_ctrl #(
   parameter int N = 8,
   parameter int R = 3
) (
   input logic                 clk,
   input logic                 rst,
   mux_serializer_ctrl_if.master bus
);
   typedef enum logic {IDLE, SHIFT} state_t;

   localparam logic [R-1:0] LAST_SEL = R'(N - 1);

   if (N < 2 || N > (1 << R)) begin : g_bad_param
      $error("mux_serializer_ctrl: N must satisfy 2 <= N <= 2**R");
   end

   state_t       state;
   logic [N-1:0] mux_a_q;
   logic [R-1:0] mux_s_q;
   logic         ser_valid_q;
   logic         busy_q;
   logic         ser_last_q;

   logic beat_done;
   logic in_ready_c;
   logic load;

   // A new word is only taken while idle or on the completed final beat, which removes the gap cycle.
   assign beat_done  = ser_valid_q & bus.ser_ready;
   assign in_ready_c = ~rst & ((state == IDLE) | (ser_last_q & bus.ser_ready));
   assign load       = bus.in_valid & in_ready_c;

   assign bus.in_ready  = in_ready_c;
   assign bus.mux_a     = mux_a_q;
   assign bus.mux_s     = mux_s_q;
   assign bus.ser_valid = ser_valid_q;
   assign bus.ser_bit   = bus.mux_y;
   assign bus.ser_last  = ser_last_q;
   assign bus.busy      = busy_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         mux_a_q     <= '0;
         mux_s_q     <= '0;
         ser_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         ser_last_q  <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (load) begin
                  mux_a_q     <= bus.in_data;
                  mux_s_q     <= '0;
                  ser_valid_q <= 1'b1;
                  busy_q      <= 1'b1;
                  ser_last_q  <= 1'b0;
                  state       <= SHIFT;
               end
            end
            SHIFT: begin
               // ser_last_q tracks mux_s == N-1, so the select never steps past the final input.
               if (beat_done) begin
                  if (!ser_last_q) begin
                     mux_s_q    <= mux_s_q + R'(1);
                     ser_last_q <= ((mux_s_q + R'(1)) == LAST_SEL);
                  end else if (load) begin
                     mux_a_q    <= bus.in_data;
                     mux_s_q    <= '0;
                     ser_last_q <= 1'b0;
                  end else begin
                     ser_valid_q <= 1'b0;
                     busy_q      <= 1'b0;
                     ser_last_q  <= 1'b0;
                     state       <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mux_serializer_ctrl.sv
// Scoreboard bench for mux_serializer_ctrl with a behavioural 8:1 mux on the mux side.
// Directed scenarios plus an all-words pass with random consumer backpressure.
module tb_mux_serializer_ctrl;
   localparam int N = 8;
   localparam int R = 3;

   typedef struct {
      logic b;
      logic l;
   } exp_bit_t;

   logic clk;
   logic rst;
   logic rand_ready;

   int total;
   int bad;
   int last_count;

   exp_bit_t     exp_bits[$];
   logic [N-1:0] exp_words[$];
   logic [N-1:0] shreg;
   logic [0:7]   basic_bits;

   mux_serializer_ctrl_if #(.N(N), .R(R)) bus ();

   mux_serializer_ctrl #(.N(N), .R(R)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   assign bus.mux_y = bus.mux_a[bus.mux_s];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic stepCycle();
      @(posedge clk);
      #1;
      if (rand_ready) bus.ser_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic waitIdle();
      for (int i = 0; i < 64 && bus.busy; i++) stepCycle();
      checkOutput("wait_idle", bus.busy, 1'b0);
   endtask

   task automatic applyStimulus(input logic [N-1:0] word);
      logic accepted;
      accepted     = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data  = word;
      for (int i = 0; i < 200 && !accepted; i++) begin
         @(negedge clk);
         accepted = bus.in_ready;
         stepCycle();
      end
      bus.in_valid = 1'b0;
      if (!accepted) checkOutput("accept_timeout", 1'b0, 1'b1);
   endtask

   // Expected bits are queued when a word is accepted and retired on each completed beat.
   always @(negedge clk) begin
      if (rst) begin
         exp_bits.delete();
         exp_words.delete();
      end else begin
         if (bus.ser_valid && bus.ser_ready) begin
            if (exp_bits.size() == 0) begin
               checkOutput("sb_unexpected_beat", 1'b1, 1'b0);
            end else begin
               exp_bit_t e;
               e = exp_bits.pop_front();
               checkOutput("sb_bit", bus.ser_bit, e.b);
               checkOutput("sb_last", bus.ser_last, e.l);
               shreg = {bus.ser_bit, shreg[N-1:1]};
               if (bus.ser_last) begin
                  last_count++;
                  if (exp_words.size() == 0) checkOutput("sb_word_missing", 1'b1, 1'b0);
                  else checkOutput("sb_word", shreg, exp_words.pop_front());
               end
            end
         end
         if (bus.in_valid && bus.in_ready) begin
            for (int i = 0; i < N; i++) begin
               exp_bit_t e;
               e.b = bus.in_data[i];
               e.l = (i == N - 1);
               exp_bits.push_back(e);
            end
            exp_words.push_back(bus.in_data);
         end
      end
   end

   initial begin
      #900000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int base;
      int sv_count;
      total        = 0;
      bad          = 0;
      last_count   = 0;
      shreg        = '0;
      basic_bits   = 8'b0110_0101;
      rand_ready   = 1'b0;
      rst          = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      bus.ser_ready = 1'b1;

      stepCycle();
      stepCycle();
      checkOutput("rst_in_ready", bus.in_ready, 1'b0);
      checkOutput("rst_ser_valid", bus.ser_valid, 1'b0);
      checkOutput("rst_busy", bus.busy, 1'b0);
      checkOutput("rst_mux_a", bus.mux_a, 8'h00);
      checkOutput("rst_mux_s", bus.mux_s, 3'd0);
      checkOutput("rst_ser_last", bus.ser_last, 1'b0);
      rst = 1'b0;
      #1;
      checkOutput("idle_in_ready", bus.in_ready, 1'b1);

      // Basic word, no stalls
      stepCycle();
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hA6;
      stepCycle();
      bus.in_valid = 1'b0;
      #1;
      for (int k = 0; k < 8; k++) begin
         checkOutput("basic_valid", bus.ser_valid, 1'b1);
         checkOutput("basic_bit", bus.ser_bit, basic_bits[k]);
         checkOutput("basic_last", bus.ser_last, (k == 7));
         stepCycle();
      end
      checkOutput("basic_idle_valid", bus.ser_valid, 1'b0);
      checkOutput("basic_idle_busy", bus.busy, 1'b0);

      // Backpressure at select 2
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hA6;
      stepCycle();
      bus.in_valid = 1'b0;
      stepCycle();
      stepCycle();
      checkOutput("bp_pre_sel", bus.mux_s, 3'd2);
      bus.ser_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         stepCycle();
         checkOutput("bp_hold_sel", bus.mux_s, 3'd2);
         checkOutput("bp_hold_bit", bus.ser_bit, 1'b1);
         checkOutput("bp_hold_valid", bus.ser_valid, 1'b1);
      end
      bus.ser_ready = 1'b1;
      stepCycle();
      checkOutput("bp_resume_sel", bus.mux_s, 3'd3);
      waitIdle();

      // Back-to-back words with no gap
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hA6;
      stepCycle();
      sv_count = 0;
      for (int cyc = 1; cyc <= 16; cyc++) begin
         bus.in_valid = (cyc == 8);
         bus.in_data  = 8'h3C;
         #1;
         if (cyc == 8) begin
            checkOutput("b2b_sel_last", bus.mux_s, 3'd7);
            checkOutput("b2b_in_ready", bus.in_ready, 1'b1);
         end
         if (cyc == 9) begin
            checkOutput("b2b_sel_restart", bus.mux_s, 3'd0);
            checkOutput("b2b_mux_a", bus.mux_a, 8'h3C);
         end
         if (bus.ser_valid) sv_count++;
         stepCycle();
      end
      bus.in_valid = 1'b0;
      checkOutput("b2b_valid_cycles", sv_count, 16);
      checkOutput("b2b_idle_valid", bus.ser_valid, 1'b0);

      // in_valid while busy is ignored
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hA6;
      stepCycle();
      bus.in_valid = 1'b0;
      repeat (4) stepCycle();
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hFF;
      #1;
      checkOutput("busy_sel", bus.mux_s, 3'd4);
      checkOutput("busy_in_ready", bus.in_ready, 1'b0);
      stepCycle();
      checkOutput("busy_mux_a", bus.mux_a, 8'hA6);
      bus.in_valid = 1'b0;
      waitIdle();
      checkOutput("busy_mux_a_end", bus.mux_a, 8'hA6);

      // Reset in the middle of a word
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hA6;
      stepCycle();
      bus.in_valid = 1'b0;
      repeat (3) stepCycle();
      checkOutput("rmid_sel", bus.mux_s, 3'd3);
      rst          = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h55;
      #1;
      checkOutput("rmid_in_ready", bus.in_ready, 1'b0);
      stepCycle();
      checkOutput("rmid_valid", bus.ser_valid, 1'b0);
      checkOutput("rmid_mux_a", bus.mux_a, 8'h00);
      checkOutput("rmid_mux_s", bus.mux_s, 3'd0);
      stepCycle();
      checkOutput("rmid_mux_a2", bus.mux_a, 8'h00);
      rst          = 1'b0;
      bus.in_valid = 1'b0;
      #1;
      checkOutput("rmid_after_ready", bus.in_ready, 1'b1);
      checkOutput("rmid_after_valid", bus.ser_valid, 1'b0);
      stepCycle();

      // All words with random consumer backpressure
      base       = last_count;
      rand_ready = 1'b1;
      for (int w = 0; w < 256; w++) applyStimulus(8'(w));
      rand_ready    = 1'b0;
      bus.ser_ready = 1'b1;
      waitIdle();
      @(negedge clk);
      checkOutput("exh_last_count", last_count - base, 256);
      checkOutput("exh_queue_empty", exp_bits.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
